vga_timing_gen: RTL

//  Parametrised raster timing generator: next generation of the 640x480 display timing block.

---
 rtl/vga_timing_gen_pkg.sv | 23 ++
 rtl/vga_timing_gen_if.sv | 27 ++
 rtl/vga_timing_gen_axis_counter.sv | 36 +++
 rtl/vga_timing_gen.sv | 116 +++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_gen_pkg: shared axis timing type, standard display modes and axis-length helper
package vga_timing_gen_pkg;

    typedef struct packed {
        int unsigned res;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } timing_t;

    typedef struct packed {
        timing_t h;
        timing_t v;
    } mode_t;

    localparam mode_t VGA_640X480_60  = '{h: '{640, 16, 96, 48},  v: '{480, 10, 2, 33}};
    localparam mode_t SVGA_800X600_60 = '{h: '{800, 40, 128, 88}, v: '{600, 1, 4, 23}};

    function automatic int unsigned total(timing_t t);
        return t.res + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel strobe into the generator, registered raster position, sync and flags out
interface vga_timing_gen_if #(
    parameter int unsigned HW     = 10,
    parameter int unsigned VW     = 10,
    parameter int unsigned FCNT_W = 8
);
    logic              pix_en;
    logic              pix_stb;
    logic [HW-1:0]     x;
    logic [VW-1:0]     y;
    logic              active;
    logic              h_sync;
    logic              v_sync;
    logic              line_start;
    logic              frame_start;
    logic [FCNT_W-1:0] frame_cnt;

    modport master (
        input  pix_en,
        output pix_stb, x, y, active, h_sync, v_sync, line_start, frame_start, frame_cnt
    );

    modport slave (
        output pix_en,
        input  pix_stb, x, y, active, h_sync, v_sync, line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// vga_timing_gen_axis_counter: wrapping position counter for one raster axis with active/sync window decode
module vga_timing_gen_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned RES  = 640,
    parameter int unsigned FP   = 16,
    parameter int unsigned SYNC = 96,
    parameter int unsigned BP   = 48,
    parameter int unsigned W    = $clog2(total(timing_t'{RES, FP, SYNC, BP}))
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_adv,
    output logic [W-1:0] o_cnt,
    output logic         o_active,
    output logic         o_sync
);
    localparam logic [W-1:0] LAST    = W'(total(timing_t'{RES, FP, SYNC, BP}) - 1);
    localparam logic [W-1:0] ACT_END = W'(RES);
    localparam logic [W-1:0] SYNC_LO = W'(RES + FP);
    localparam logic [W-1:0] SYNC_HI = W'(RES + FP + SYNC - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Step on request, wrapping after the last position of the axis
    always_comb cnt_d = !i_adv ? cnt_q : (cnt_q == LAST ? '0 : cnt_q + 1'b1);

    // Position register; restarts at the first pixel/line on reset
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;

    assign o_cnt    = cnt_q;
    assign o_active = cnt_q < ACT_END;
    assign o_sync   = cnt_q >= SYNC_LO && cnt_q <= SYNC_HI;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator; DT_FRAME_CNT_EN enables the frame counter
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned G_H_RES  = VGA_640X480_60.h.res,
    parameter int unsigned G_H_FP   = VGA_640X480_60.h.fp,
    parameter int unsigned G_H_SYNC = VGA_640X480_60.h.sync,
    parameter int unsigned G_H_BP   = VGA_640X480_60.h.bp,
    parameter int unsigned G_V_RES  = VGA_640X480_60.v.res,
    parameter int unsigned G_V_FP   = VGA_640X480_60.v.fp,
    parameter int unsigned G_V_SYNC = VGA_640X480_60.v.sync,
    parameter int unsigned G_V_BP   = VGA_640X480_60.v.bp,
    parameter bit          G_H_POL  = 1'b0,
    parameter bit          G_V_POL  = 1'b0,
    parameter int unsigned G_FCNT_W = 8
) (
    input logic              i_clk,
    input logic              i_rst_n,
    vga_timing_gen_if.master bus
);
    localparam int unsigned   H_TOTAL = total(timing_t'{G_H_RES, G_H_FP, G_H_SYNC, G_H_BP});
    localparam int unsigned   V_TOTAL = total(timing_t'{G_V_RES, G_V_FP, G_V_SYNC, G_V_BP});
    localparam int unsigned   HW      = $clog2(H_TOTAL);
    localparam int unsigned   VW      = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);

    if (G_H_RES == 0 || G_H_FP == 0 || G_H_SYNC == 0 || G_H_BP == 0 ||
        G_V_RES == 0 || G_V_FP == 0 || G_V_SYNC == 0 || G_V_BP == 0) begin : g_bad_params
        $error("vga_timing_gen: every resolution, porch and sync parameter must be >= 1");
    end

    if ($bits(bus.x) != HW || $bits(bus.y) != VW || $bits(bus.frame_cnt) != G_FCNT_W) begin : g_bad_bus
        $error("vga_timing_gen: interface widths do not match the timing parameters");
    end

    logic [HW-1:0] h_cnt, x_q;
    logic [VW-1:0] v_cnt, y_q;
    logic          h_act, v_act, h_win, v_win;
    logic          act_d, hs_d, vs_d, ls_d, fs_d;
    logic          stb_q, act_q, hs_q, vs_q, ls_q, fs_q;

    vga_timing_gen_axis_counter #(
        .RES(G_H_RES), .FP(G_H_FP), .SYNC(G_H_SYNC), .BP(G_H_BP), .W(HW)
    ) u_h (
        .i_clk, .i_rst_n,
        .i_adv    (bus.pix_en),
        .o_cnt    (h_cnt),
        .o_active (h_act),
        .o_sync   (h_win)
    );

    vga_timing_gen_axis_counter #(
        .RES(G_V_RES), .FP(G_V_FP), .SYNC(G_V_SYNC), .BP(G_V_BP), .W(VW)
    ) u_v (
        .i_clk, .i_rst_n,
        .i_adv    (bus.pix_en && h_cnt == H_LAST),
        .o_cnt    (v_cnt),
        .o_active (v_act),
        .o_sync   (v_win)
    );

    // Decode flags and sync levels for the pixel the counters point at
    always_comb begin
        act_d = h_act && v_act;
        hs_d  = h_win ? G_H_POL : ~G_H_POL;
        vs_d  = v_win ? G_V_POL : ~G_V_POL;
        ls_d  = h_cnt == '0;
        fs_d  = ls_d && v_cnt == '0;
    end

    // Present the decoded pixel one clock after its strobe; hold between strobes
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            stb_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            act_q <= 1'b0;
            hs_q  <= ~G_H_POL;
            vs_q  <= ~G_V_POL;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            stb_q <= bus.pix_en;
            if (bus.pix_en) begin
                x_q   <= h_cnt;
                y_q   <= v_cnt;
                act_q <= act_d;
                hs_q  <= hs_d;
                vs_q  <= vs_d;
                ls_q  <= ls_d;
                fs_q  <= fs_d;
            end
        end

    assign bus.pix_stb     = stb_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.active      = act_q;
    assign bus.h_sync      = hs_q;
    assign bus.v_sync      = vs_q;
    assign bus.line_start  = ls_q;
    assign bus.frame_start = fs_q;

`ifdef DT_FRAME_CNT_EN
    logic [G_FCNT_W-1:0] fcnt_q;

    // Count frames as their first pixel is loaded into the outputs
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)                fcnt_q <= '0;
        else if (bus.pix_en && fs_d) fcnt_q <= fcnt_q + 1'b1;

    assign bus.frame_cnt = fcnt_q;
`else
    assign bus.frame_cnt = {G_FCNT_W{1'b0}};
`endif
endmodule
